regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor of the 32x16 register file for the pipelined RISC datapath.
- Generalised in data width and depth, with two read ports and one write port.
- Adds write-through bypass, an optional hardwired-zero register 0, and a per-register pending-write scoreboard that decode uses to detect RAW hazards and stall.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes, releases).

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- ZERO_REG, 0, when 1: register 0 always reads 0, ignores writes, and is never busy.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- write_en  input  1  writeback write strobe
- wR_addr  input  ADDR_W  write address
- write_data  input  DATA_W  write data
- rR1_en  input  1  read port 1 enable
- rR1_addr  input  ADDR_W  read port 1 address
- rR2_en  input  1  read port 2 enable
- rR2_addr  input  ADDR_W  read port 2 address
- rsv_en  input  1  reserve strobe from decode; marks the destination pending
- rsv_addr  input  ADDR_W  destination register to reserve
- R1_data  output  DATA_W  read port 1 data
- R2_data  output  DATA_W  read port 2 data
- busy1  output  1  rR1_addr has an outstanding write
- busy2  output  1  rR2_addr has an outstanding write
- hazard  output  1  (rR1_en & busy1) | (rR2_en & busy2)

Behaviour:
- State is regs[0 .. 2**ADDR_W-1] of DATA_W bits, plus a pend[] bit vector of the same depth.
- Reset (reset=0, asynchronous):
  - All regs and all pend bits clear to 0 immediately.
  - Held while reset=0; writes and reserves are ignored.
- Write: on the rising clk edge with write_en=1 and reset=1, regs[wR_addr] <= write_data and pend[wR_addr] <= 0.
  - Exception: ZERO_REG=1 and wR_addr=0, in which case there is no effect.
- Reserve: on the rising clk edge with rsv_en=1, pend[rsv_addr] <= 1.
  - Ignored when ZERO_REG=1 and rsv_addr=0.
- Reserve and write to the same address in the same edge: reserve wins, so pend stays 1. The new producer supersedes the retiring one; the data write still happens.
- Reserve and write to different addresses in the same edge: both take effect.
- Reads are combinational with 0 cycles latency:
  - rRx_en=0 -> R_x data = 0. Driven, never high-Z; tri-state buffers are not used.
  - rRx_en=1 -> R_x data = regs[rRx_addr].
  - Bypass: if write_en=1 and wR_addr==rRx_addr, R_x data = write_data (write-through, same cycle).
  - ZERO_REG=1 and rRx_addr=0 -> R_x data = 0, overriding the bypass.
- busyX is combinational: pend[rRx_addr] & ~(write_en & wR_addr==rRx_addr).
  - A retiring write clears the hazard in the same cycle, consistent with the bypass.
  - busyX is 0 for address 0 when ZERO_REG=1.
  - busyX is independent of rRx_en; hazard qualifies it with the enable.
- Outputs during reset: pend=0, so busy1, busy2 and hazard are 0. Data reads return 0 unless a write_en bypass is active.
- Reset asserted mid-operation discards all pending reservations; the pipeline is expected to flush alongside it.
- Write and reserve addresses wrap naturally within ADDR_W; no out-of-range condition exists.
- Address X/Z on disabled ports must not propagate to outputs.

Test Plan:
1. Reset then read: assert reset=0, release it, read r7 and r31 on both ports -> R1_data=R2_data=0x0000, busy1=busy2=hazard=0.
2. Write/readback: write 0xBEEF to r5; on the next cycle read r5 on port 1 and r5 on port 2 -> both 0xBEEF. Read with rR1_en=0 -> R1_data=0x0000.
3. Bypass: in one cycle, write_en=1, wR_addr=9, write_data=0x1234, rR1_addr=9 -> R1_data=0x1234 in the same cycle, and regs[9]=0x1234 after the edge.
4. Scoreboard:
   - Reserve r3, then read r3 with rR2_en=1 -> busy2=1, hazard=1.
   - Write r3=0x00AA -> same-cycle busy2=0, R2_data=0x00AA.
   - After the edge, busy2=0.
5. Simultaneous events: with pend[4]=1, apply rsv_en=1 and write_en=1 on r4 in the same edge -> regs[4] updated and pend[4] still 1. Separately, reserve r6 and write r8 together -> pend[6]=1, pend[8]=0.
6. ZERO_REG=1 with reset mid-operation:
   - Write 0xFFFF to r0 and reserve r0 -> r0 reads 0x0000 with write_en bypass active, busy=0.
   - Reserve r2, then pulse reset=0 between edges -> busy for r2 drops to 0 immediately, and r5 reads 0x0000.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-through bypass and a pending-write
// scoreboard that decode uses to detect RAW hazards.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] wR_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rR1_en,
    input  logic [ADDR_W-1:0] rR1_addr,
    input  logic              rR2_en,
    input  logic [ADDR_W-1:0] rR2_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] R1_data,
    output logic [DATA_W-1:0] R2_data,
    output logic              busy1,
    output logic              busy2,
    output logic              hazard
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic wr_ok;
    logic rsv_ok;

    assign wr_ok  = write_en && !(ZR && wR_addr == '0);
    assign rsv_ok = rsv_en && !(ZR && rsv_addr == '0);

    // Reserve is applied last so it wins over a retiring write to the same reg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend <= '0;
        end else begin
            if (wr_ok) begin
                regs[wR_addr] <= write_data;
                pend[wR_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                pend[rsv_addr] <= 1'b1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(
        input logic              en,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] d;
        d = '0;
        if (en) begin
            if (ZR && addr == '0) begin
                d = '0;
            end else if (write_en && wR_addr == addr) begin
                d = write_data;
            end else begin
                d = regs[addr];
            end
        end
        return d;
    endfunction

    // A write retiring this cycle already satisfies the consumer.
    function automatic logic busy_of(input logic [ADDR_W-1:0] addr);
        logic b;
        b = pend[addr] && !(write_en && wR_addr == addr);
        if (ZR && addr == '0) begin
            b = 1'b0;
        end
        return b;
    endfunction

    always_comb begin
        R1_data = rd_port(rR1_en, rR1_addr);
        R2_data = rd_port(rR2_en, rR2_addr);
        busy1   = busy_of(rR1_addr);
        busy2   = busy_of(rR2_addr);
        hazard  = (rR1_en && busy1) || (rR2_en && busy2);
    end

endmodule
